// File: rtl/matmul_pkg.sv
// Shared types and default geometry for the matmul host controller.
package matmul_pkg;

  localparam int MM_DATA_WIDTH = 32;
  localparam int MM_ADDR_WIDTH = 6;
  localparam int MM_N          = 8;
  localparam int MAT_WORDS     = MM_N * MM_N;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    LOAD_Y,
    START,
    WAIT,
    FETCH,
    SEND,
    ERROR
  } ctrl_state_t;

endpackage

// File: rtl/matmul_ctrl.sv
// Host controller: loads X/Y RAMs, starts the core, streams Z out.
// Optional WAIT watchdog enabled by MATMUL_CTRL_TIMEOUT_EN.
module matmul_ctrl
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH     = MM_DATA_WIDTH,
  parameter int ADDR_WIDTH     = MM_ADDR_WIDTH,
  parameter int N              = MM_N,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] x_din,
  output logic [DATA_WIDTH-1:0] y_din,
  output logic [ADDR_WIDTH-1:0] x_addr,
  output logic [ADDR_WIDTH-1:0] y_addr,
  output logic                  x_wr_en,
  output logic                  y_wr_en,
  output logic [ADDR_WIDTH-1:0] z_addr,
  input  logic [DATA_WIDTH-1:0] z_dout,
  output logic                  mm_start,
  input  logic                  mm_done,
  output logic                  busy,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(N * N - 1);

  ctrl_state_t           state;
  ctrl_state_t           state_n;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] cnt_n;
  logic                  mm_done_q;
  logic                  done_rise;
  logic                  timeout;

  assign done_rise = mm_done & ~mm_done_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mm_done_q <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mm_done_q <= mm_done;
    end
  end

`ifdef MATMUL_CTRL_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST =
    WDW'(TIMEOUT_CYCLES - 1);

  logic [WDW-1:0] wd;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd <= '0;
    end else if (state == WAIT) begin
      wd <= wd + WDW'(1);
    end else begin
      wd <= '0;
    end
  end

  assign timeout = (state == WAIT) && (wd == WD_LAST);
  assign error   = (state == ERROR);
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign timeout    = 1'b0;
  assign error      = 1'b0;
`endif

  assign busy = (state != IDLE) && (state != LOAD_X);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    x_din     = '0;
    y_din     = '0;
    x_addr    = '0;
    y_addr    = '0;
    x_wr_en   = 1'b0;
    y_wr_en   = 1'b0;
    z_addr    = '0;
    mm_start  = 1'b0;
    unique case (state)
      IDLE: begin
        state_n = LOAD_X;
        cnt_n   = '0;
      end
      LOAD_X: begin
        in_ready = 1'b1;
        x_addr   = cnt;
        x_din    = in_data;
        if (in_valid) begin
          x_wr_en = 1'b1;
          if (cnt == LAST) begin
            state_n = LOAD_Y;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      LOAD_Y: begin
        in_ready = 1'b1;
        y_addr   = cnt;
        y_din    = in_data;
        if (in_valid) begin
          y_wr_en = 1'b1;
          if (cnt == LAST) begin
            state_n = START;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      START: begin
        mm_start = 1'b1;
        state_n  = WAIT;
      end
      // Only a fresh 0->1 edge completes; a held level is ignored.
      WAIT: begin
        if (done_rise) begin
          state_n = FETCH;
          cnt_n   = '0;
        end else if (timeout) begin
          state_n = ERROR;
        end
      end
      FETCH: begin
        z_addr  = cnt;
        state_n = SEND;
      end
      SEND: begin
        z_addr    = cnt;
        out_data  = z_dout;
        out_valid = 1'b1;
        if (out_ready) begin
          if (cnt == LAST) begin
            state_n = IDLE;
          end else begin
            cnt_n   = cnt + 1'b1;
            state_n = FETCH;
          end
        end
      end
      ERROR: begin
        state_n = ERROR;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: doc/matmul_ctrl.md
# matmul_ctrl

Host-side controller that is the other end of the `matmul` memory/start-done interface. It accepts a stream of 2·N·N operand words and writes them into the X and Y buffer RAMs, pulses `mm_start`, waits for `mm_done`, then reads the N·N result words out of the Z RAM as a valid/ready stream. It sits between the system stream fabric and the matmul core plus its three buffer RAMs.

## Interface
- `DATA_WIDTH`, 32, word width of operands and results
- `ADDR_WIDTH`, 6, RAM address width; N·N ≤ 2^ADDR_WIDTH required
- `N`, 8, matrix dimension
- `TIMEOUT_CYCLES`, 1024, watchdog limit in WAIT (used only with the macro)

- `clock`  in  1  single clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `in_data`  in  DATA_WIDTH  operand word, row-major X then row-major Y
- `in_valid`  in  1  operand word valid
- `in_ready`  out  1  controller accepts operand word
- `out_data`  out  DATA_WIDTH  result word, row-major Z
- `out_valid`  out  1  result word valid
- `out_ready`  in  1  downstream accepts result word
- `x_din`, `y_din`  out  DATA_WIDTH  RAM write data (= `in_data`)
- `x_addr`, `y_addr`  out  ADDR_WIDTH  RAM write address
- `x_wr_en`, `y_wr_en`  out  1  RAM write enable
- `z_addr`  out  ADDR_WIDTH  Z RAM read address
- `z_dout`  in  DATA_WIDTH  Z RAM read data, valid 1 cycle after `z_addr`
- `mm_start`  out  1  start pulse to matmul core
- `mm_done`  in  1  done level from matmul core
- `busy`  out  1  high in every state except IDLE and LOAD_X
- `error`  out  1  watchdog fired (sticky)

## Operation
- States: IDLE, LOAD_X, LOAD_Y, START, WAIT, FETCH, SEND, ERROR. Index counter `cnt` is ADDR_WIDTH bits.
- IDLE: all outputs 0; next cycle → LOAD_X, `cnt`=0.
- LOAD_X: `in_ready`=1. On `in_valid`: `x_wr_en`=1 and `x_addr`=`cnt` in the same cycle. `cnt`++. At `cnt`==N·N−1 → LOAD_Y, `cnt`=0.
- LOAD_Y: the same, on the Y port. After the last word → START.
- START: `mm_start`=1 for exactly one cycle → WAIT.
- WAIT: completion is the rising edge of `mm_done` (`mm_done` & ~`mm_done_q`). A stale high level never completes. On completion → FETCH, `cnt`=0.
- FETCH: `z_addr`=`cnt` for one cycle → SEND.
- SEND: `z_addr` is held at `cnt`. `out_data`=`z_dout` and `out_valid`=1, held stable until `out_ready`. On handshake: if `cnt`==N·N−1 → IDLE, else `cnt`++ → FETCH.
- `in_ready`=0 outside LOAD_X/LOAD_Y. `out_valid`=0 outside SEND. Write enables are never asserted without an accepted word.
- Data is passed through unmodified; no arithmetic beyond the counter.

## Timing
- Reset (asynchronous, active-low): state=IDLE, `cnt`=0, `mm_done_q`=0, watchdog=0, `error`=0. All outputs 0 while reset is asserted.
- Reset mid-operation aborts immediately. No partial writes after deassertion. The next load starts at address 0.
- Load throughput: 1 word/cycle. Unload throughput: 1 word per 2 cycles (FETCH + SEND).
- Minimum latency from the last Y word accepted to `mm_start`: 1 cycle.
- Minimum latency from the `mm_done` rising edge to first `out_valid`: 2 cycles.
- `in_valid` low mid-load: `cnt` holds and no write occurs. `out_ready` low: the SEND word holds.

## Configuration
- `MATMUL_CTRL_TIMEOUT_EN` defined:
  - A watchdog counts cycles in WAIT.
  - Reaching `TIMEOUT_CYCLES` without completion → ERROR.
  - ERROR: `error`=1 and all handshakes 0, until reset.
- Macro undefined: no watchdog, ERROR state unreachable, `error` tied 0.

## Structure
- Shared package `matmul_pkg`:
  - `ctrl_state_t` enum (3 bits)
  - default `N`, `DATA_WIDTH`, `ADDR_WIDTH` constants
  - `MAT_WORDS` = N·N
- No sub-module required. A behavioural 1-cycle-read RAM model `matmul_ram` is shared by testbenches only.

## Test plan
- Stream X=identity, Y[i]=i (128 words, `in_valid` constant). Required: exactly one `mm_start` pulse; after done, Z = 0..63 in row order on `out_data`.
- Insert `in_valid` gaps every 3rd word. Required: `x_addr`/`y_addr` sequence unchanged, no writes during gaps, same Z result.
- Hold `out_ready` low for 10 cycles on word 5. Required: `out_data` and `out_valid` stable, no skipped or duplicated words.
- Hold `mm_done` high before START (stale level). Required: the controller stays in WAIT until a fresh 0→1 edge.
- Assert `reset` during LOAD_Y word 20. Required: all outputs 0. After deassertion the next word is written at `x_addr`=0.
- Macro on, `TIMEOUT_CYCLES`=50, `mm_done` never rises. Required: `error`=1 at WAIT cycle 50, `out_valid`/`in_ready` stay 0 until reset.
